// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into GRB pixel words and detects the frame latch gap.
module ws2812_rx #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int LATCH_US        = 40
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Data,
  output logic [23:0] o_Data,
  output logic        o_Data_Valid,
  output logic [7:0]  o_Pixel_Index,
  output logic        o_Frame_Done,
  output logic [8:0]  o_Pixel_Count,
  output logic        o_Error,
  output logic        o_Busy
);
  localparam int T_MIN = CLOCK_FREQUENCY / 6666667;
  localparam int T_ONE = CLOCK_FREQUENCY / 1600000;
  localparam int T_MAX = CLOCK_FREQUENCY / 1000000;
  localparam int T_LAT = CLOCK_FREQUENCY / 1000000 * LATCH_US;
  localparam int HW = $clog2(T_MAX + 2);
  localparam int LW = $clog2(T_LAT + 1);
  localparam logic [HW-1:0] H_MIN = HW'(T_MIN);
  localparam logic [HW-1:0] H_ONE = HW'(T_ONE);
  localparam logic [HW-1:0] H_MAX = HW'(T_MAX);
  localparam logic [LW-1:0] L_LAT = LW'(T_LAT);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic rise, fall, bit_in;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [22:0] sr_q, sr_d;
  logic [23:0] shifted;
  logic [4:0] bcnt_q, bcnt_d;
  logic [8:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic [7:0] idx_q, idx_d;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= SYNC;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      sr_q    <= '0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= i_Data;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Counters clear while the other level is present, so the first clock of a level counts as 1.
  always_comb begin
    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    hcnt_d  = !s2_q ? '0 : (&hcnt_q ? hcnt_q : hcnt_q + HW'(1));
    lcnt_d  = s2_q ? '0 : (&lcnt_q ? lcnt_q : lcnt_q + LW'(1));
    bit_in  = hcnt_q >= H_ONE;
    shifted = {sr_q, bit_in};
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      SYNC: begin
        bcnt_d  = '0;
        pcnt_d  = '0;
        state_d = lcnt_q >= L_LAT ? IDLE : SYNC;
      end
      IDLE: state_d = rise ? HIGH : IDLE;
      HIGH: begin
        if (hcnt_q > H_MAX) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end else if (fall && hcnt_q < H_MIN) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end else if (fall) begin
          state_d = LOW;
          sr_d    = shifted[22:0];
          bcnt_d  = bcnt_q == 5'd23 ? 5'd0 : bcnt_q + 5'd1;
          if (bcnt_q == 5'd23) begin
            data_d  = shifted;
            valid_d = 1'b1;
            idx_d   = pcnt_q[8] ? 8'hFF : pcnt_q[7:0];
            pcnt_d  = &pcnt_q ? pcnt_q : pcnt_q + 9'd1;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (lcnt_q >= L_LAT) begin
          done_d  = 1'b1;
          cnt_d   = pcnt_q;
          err_d   = bcnt_q != 5'd0;
          bcnt_d  = '0;
          pcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign o_Data        = data_q;
  assign o_Data_Valid  = valid_q;
  assign o_Pixel_Index = idx_q;
  assign o_Frame_Done  = done_q;
  assign o_Pixel_Count = cnt_q;
  assign o_Error       = err_q;
  assign o_Busy        = state_q == HIGH || state_q == LOW;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed scenarios for the WS2812 receiver with hand-computed expectations.
module tb_ws2812_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic [23:0] o_Data;
  logic o_Data_Valid, o_Frame_Done, o_Error, o_Busy;
  logic [7:0] o_Pixel_Index;
  logic [8:0] o_Pixel_Count;

  ws2812_rx dut (
    .i_Clock(clk), .i_Reset(rst), .i_Data(din),
    .o_Data(o_Data), .o_Data_Valid(o_Data_Valid), .o_Pixel_Index(o_Pixel_Index),
    .o_Frame_Done(o_Frame_Done), .o_Pixel_Count(o_Pixel_Count),
    .o_Error(o_Error), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures = 0;
  logic [23:0] vq[$];
  logic [7:0] iq[$];
  logic [8:0] fq[$];
  logic fe[$];
  int nerr = 0;
  int clash = 0;

  always @(negedge clk) begin
    if (o_Data_Valid) begin
      vq.push_back(o_Data);
      iq.push_back(o_Pixel_Index);
      if (o_Error) clash++;
    end
    if (o_Frame_Done) begin
      fq.push_back(o_Pixel_Count);
      fe.push_back(o_Error);
    end
    if (o_Error) nerr++;
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin drive(1'b1, 84); drive(1'b0, 42); end
    else begin drive(1'b1, 42); drive(1'b0, 84); end
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic latch();
    drive(1'b0, 4100);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    assertions++;
    if ({o_Data, o_Data_Valid, o_Pixel_Index, o_Frame_Done, o_Pixel_Count, o_Error, o_Busy} !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h v=%b idx=%0d fd=%b cnt=%0d err=%b busy=%b, want all 0",
               o_Data, o_Data_Valid, o_Pixel_Index, o_Frame_Done, o_Pixel_Count, o_Error, o_Busy);
    end
    rst = 1'b0;
    latch();
  endtask

  task automatic test_single();
    int v0 = vq.size(), f0 = fq.size(), e0 = nerr;
    send_pixel(24'hA53C0F);
    assertions++;
    if (o_Busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", o_Busy); end
    latch();
    assertions++;
    if (vq.size() - v0 !== 1) begin failures++; $display("FAIL single_nvalid: got %0d want 1", vq.size() - v0); end
    assertions++;
    if ((vq.size() > v0 ? vq[v0] : 24'hxxxxxx) !== 24'hA53C0F) begin failures++; $display("FAIL single_data: got %h want a53c0f", vq.size() > v0 ? vq[v0] : 24'h0); end
    assertions++;
    if ((iq.size() > v0 ? iq[v0] : 8'hxx) !== 8'd0) begin failures++; $display("FAIL single_index: got %0d want 0", iq.size() > v0 ? iq[v0] : 8'd0); end
    assertions++;
    if ((fq.size() > f0 ? fq[f0] : 9'hxxx) !== 9'd1) begin failures++; $display("FAIL single_count: got %0d want 1 (frames %0d)", fq.size() > f0 ? fq[f0] : 9'd0, fq.size() - f0); end
    assertions++;
    if (nerr - e0 !== 0) begin failures++; $display("FAIL single_err: got %0d errors want 0", nerr - e0); end
    assertions++;
    if (o_Busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b want 0", o_Busy); end
    assertions++;
    if (o_Data !== 24'hA53C0F) begin failures++; $display("FAIL single_hold: got %h want a53c0f", o_Data); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] px[3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
    int v0 = vq.size(), f0 = fq.size();
    for (int k = 0; k < 3; k++) send_pixel(px[k]);
    latch();
    assertions++;
    if (vq.size() - v0 !== 3) begin failures++; $display("FAIL b2b_nvalid: got %0d want 3", vq.size() - v0); end
    for (int k = 0; k < 3; k++) begin
      assertions++;
      if ((vq.size() > v0 + k ? vq[v0 + k] : 24'hxxxxxx) !== px[k]) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", k, vq.size() > v0 + k ? vq[v0 + k] : 24'h0, px[k]); end
      assertions++;
      if ((iq.size() > v0 + k ? iq[v0 + k] : 8'hxx) !== 8'(k)) begin failures++; $display("FAIL b2b_index%0d: got %0d want %0d", k, iq.size() > v0 + k ? iq[v0 + k] : 8'd0, k); end
    end
    assertions++;
    if ((fq.size() > f0 ? fq[f0] : 9'hxxx) !== 9'd3) begin failures++; $display("FAIL b2b_count: got %0d want 3", fq.size() > f0 ? fq[f0] : 9'd0); end
  endtask

  task automatic test_threshold();
    int v0 = vq.size();
    drive(1'b1, 61); drive(1'b0, 65);
    drive(1'b1, 62); drive(1'b0, 64);
    for (int i = 0; i < 22; i++) send_bit(1'b0);
    latch();
    assertions++;
    if ((vq.size() > v0 ? vq[v0] : 24'hxxxxxx) !== 24'h400000) begin failures++; $display("FAIL threshold_data: got %h want 400000", vq.size() > v0 ? vq[v0] : 24'h0); end
  endtask

  task automatic test_long_high();
    int v0 = vq.size(), f0 = fq.size(), e0 = nerr, first = 0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    din = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (o_Error && first == 0) first = i;
    end
    drive(1'b0, 50);
    send_pixel(24'hFFFFFF);
    latch();
    assertions++;
    if (first !== 104) begin failures++; $display("FAIL long_err_time: got clock %0d want 104", first); end
    assertions++;
    if (nerr - e0 !== 1) begin failures++; $display("FAIL long_nerr: got %0d want 1", nerr - e0); end
    assertions++;
    if (vq.size() - v0 !== 0) begin failures++; $display("FAIL long_nvalid: got %0d want 0", vq.size() - v0); end
    assertions++;
    if (fq.size() - f0 !== 0) begin failures++; $display("FAIL long_nframe: got %0d want 0", fq.size() - f0); end
  endtask

  task automatic test_glitch();
    int v0 = vq.size(), f0 = fq.size(), e0 = nerr;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    drive(1'b1, 5);
    drive(1'b0, 50);
    send_pixel(24'hFFFFFF);
    latch();
    assertions++;
    if (nerr - e0 !== 1) begin failures++; $display("FAIL glitch_nerr: got %0d want 1", nerr - e0); end
    assertions++;
    if (vq.size() - v0 !== 0) begin failures++; $display("FAIL glitch_nvalid: got %0d want 0", vq.size() - v0); end
    assertions++;
    if (fq.size() - f0 !== 0) begin failures++; $display("FAIL glitch_nframe: got %0d want 0", fq.size() - f0); end
  endtask

  task automatic test_partial();
    int v0 = vq.size(), f0 = fq.size(), e0 = nerr;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    latch();
    assertions++;
    if (fq.size() - f0 !== 1) begin failures++; $display("FAIL partial_nframe: got %0d want 1", fq.size() - f0); end
    assertions++;
    if ((fq.size() > f0 ? fq[f0] : 9'hxxx) !== 9'd0) begin failures++; $display("FAIL partial_count: got %0d want 0", fq.size() > f0 ? fq[f0] : 9'd0); end
    assertions++;
    if ((fe.size() > f0 ? fe[f0] : 1'bx) !== 1'b1) begin failures++; $display("FAIL partial_err_with_done: got %b want 1", fe.size() > f0 ? fe[f0] : 1'b0); end
    assertions++;
    if (nerr - e0 !== 1 || vq.size() - v0 !== 0) begin failures++; $display("FAIL partial_side: got errors=%0d valids=%0d want 1 and 0", nerr - e0, vq.size() - v0); end
  endtask

  task automatic test_mid_reset();
    logic [23:0] p = 24'hABCDEF;
    int v0 = vq.size(), f0 = fq.size();
    for (int i = 23; i >= 12; i--) send_bit(p[i]);
    assertions++;
    if (o_Busy !== 1'b1) begin failures++; $display("FAIL midrst_busy: got %b want 1", o_Busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertions++;
    if ({o_Data, o_Data_Valid, o_Pixel_Index, o_Frame_Done, o_Pixel_Count, o_Error, o_Busy} !== 46'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got data=%h v=%b idx=%0d fd=%b cnt=%0d err=%b busy=%b, want all 0",
               o_Data, o_Data_Valid, o_Pixel_Index, o_Frame_Done, o_Pixel_Count, o_Error, o_Busy);
    end
    for (int i = 11; i >= 0; i--) send_bit(p[i]);
    latch();
    assertions++;
    if (vq.size() - v0 !== 0 || fq.size() - f0 !== 0) begin failures++; $display("FAIL midrst_quiet: got valids=%0d frames=%0d want 0 and 0", vq.size() - v0, fq.size() - f0); end
    send_pixel(24'h123456);
    latch();
    assertions++;
    if ((vq.size() > v0 ? vq[v0] : 24'hxxxxxx) !== 24'h123456) begin failures++; $display("FAIL midrst_data: got %h want 123456", vq.size() > v0 ? vq[v0] : 24'h0); end
    assertions++;
    if ((iq.size() > v0 ? iq[v0] : 8'hxx) !== 8'd0) begin failures++; $display("FAIL midrst_index: got %0d want 0", iq.size() > v0 ? iq[v0] : 8'd0); end
    assertions++;
    if ((fq.size() > f0 ? fq[f0] : 9'hxxx) !== 9'd1) begin failures++; $display("FAIL midrst_count: got %0d want 1", fq.size() > f0 ? fq[f0] : 9'd0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_threshold();
    test_long_high();
    test_glitch();
    test_partial();
    test_mid_reset();
    assertions++;
    if (clash !== 0) begin failures++; $display("FAIL valid_error_overlap: got %0d want 0", clash); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
